// File: rtl/dmem_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Holds the arbiter state encoding, default bus widths and the word-alignment helper.
package dmem_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE1 = 1'b1
  } dmem_state_e;

  // Word accesses only: any nonzero byte offset is misaligned.
  function automatic logic is_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-port read-return register: one-cycle rvalid/err pulse plus held read data.
module dmem_rsp_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd_take,
  input  logic          err_take,
  input  logic [DW-1:0] rd_data,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          err
);

  // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_take;
      err    <= err_take;
      if (rd_take) rdata <= rd_data;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: port 0 (MEM stage) has priority,
// port 1 (loader/debug) is forced through after MAX_WAIT consecutive denied cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          stall0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data
);

  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  dmem_state_e   state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wcnt_next;
  logic          force1;
  logic          sel_we;
  logic          unused_err0;

  // A forced slot only applies while port 1 is still asking; otherwise normal priority.
  assign force1 = (state == ST_FORCE1) && req1;
  assign gnt1   = req1 && (force1 || !req0);
  assign gnt0   = req0 && !force1;
  assign stall0 = req0 && !gnt0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_we         = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (gnt0) begin
      sel_we         = we0;
      mem_address    = addr0;
      mem_write_data = wdata0;
    end else if (gnt1) begin
      sel_we         = we1;
      mem_address    = addr1;
      mem_write_data = wdata1;
    end
  end

  // Misaligned writes are granted but never reach the array; reset gates the strobe directly.
  assign mem_write = sel_we && is_aligned(mem_address[1:0]) && reset_n;

  always_comb begin
    wcnt_next = wcnt;
    if (gnt1 || !req1) wcnt_next = '0;
    else if (wcnt != WAIT_LIMIT) wcnt_next = wcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_NORMAL;
      wcnt  <= '0;
    end else begin
      wcnt <= wcnt_next;
      case (state)
        ST_NORMAL: if (wcnt_next == WAIT_LIMIT) state <= ST_FORCE1;
        ST_FORCE1: if (gnt1 || !req1) state <= ST_NORMAL;
        default:   state <= ST_NORMAL;
      endcase
    end
  end

  // Port 0 never reports errors; its error flop is tied off and optimised away.
  dmem_rsp_reg #(.DW(DW)) u_rsp0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_take  (gnt0 && !we0),
    .err_take (1'b0),
    .rd_data  (mem_read_data),
    .rvalid   (rvalid0),
    .rdata    (rdata0),
    .err      (unused_err0)
  );

  dmem_rsp_reg #(.DW(DW)) u_rsp1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_take  (gnt1 && !we1),
    .err_take (gnt1 && !is_aligned(addr1[1:0])),
    .rd_data  (mem_read_data),
    .rvalid   (rvalid1),
    .rdata    (rdata1),
    .err      (err1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int CW       = 3;

  logic          clk;
  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, stall0, rvalid0, gnt1, rvalid1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;

  // Environment memory (driven by the DUT) and an independent reference copy.
  logic [DW-1:0] tb_mem  [64];
  logic [DW-1:0] ref_mem [64];

  int n_checks;
  int n_fail;

  // Reference model state.
  int            denied1;
  logic          exp_rv0, exp_rv1, exp_err1;
  logic [DW-1:0] exp_rd0, exp_rd1;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .gnt0           (gnt0),
    .stall0         (stall0),
    .rvalid0        (rvalid0),
    .rdata0         (rdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .gnt1           (gnt1),
    .rvalid1        (rvalid1),
    .rdata1         (rdata1),
    .err1           (err1),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = tb_mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write) tb_mem[mem_address[7:2]] <= mem_write_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    denied1  = 0;
    exp_rv0  = 1'b0;
    exp_rv1  = 1'b0;
    exp_err1 = 1'b0;
    exp_rd0  = '0;
    exp_rd1  = '0;
  endtask

  task automatic drive_idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  // One clock cycle: check last cycle's responses, apply inputs, check the grant decision,
  // then advance the reference model.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic          g0, g1, ew;
    logic [31:0]   ea, ed;
    @(posedge clk);
    #1;
    check("rvalid0", rvalid0, exp_rv0);
    check("rdata0",  rdata0,  exp_rd0);
    check("rvalid1", rvalid1, exp_rv1);
    check("rdata1",  rdata1,  exp_rd1);
    check("err1",    err1,    exp_err1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (r1 && denied1 >= MAX_WAIT) begin g1 = 1'b1; g0 = 1'b0; end
    else if (r0)                   begin g0 = 1'b1; g1 = 1'b0; end
    else                           begin g0 = 1'b0; g1 = r1;   end
    ea = g0 ? a0 : (g1 ? a1 : 32'd0);
    ed = g0 ? d0 : (g1 ? d1 : 32'd0);
    ew = (g0 && w0 && a0[1:0] == 2'b00) || (g1 && w1 && a1[1:0] == 2'b00);
    check("gnt0",           gnt0,           g0);
    check("gnt1",           gnt1,           g1);
    check("stall0",         stall0,         r0 && !g0);
    check("mem_write",      mem_write,      ew);
    check("mem_address",    mem_address,    ea);
    check("mem_write_data", mem_write_data, ed);
    exp_rv0 = g0 && !w0;
    if (exp_rv0) exp_rd0 = ref_mem[a0[7:2]];
    exp_rv1 = g1 && !w1;
    if (exp_rv1) exp_rd1 = ref_mem[a1[7:2]];
    exp_err1 = g1 && a1[1:0] != 2'b00;
    if (ew) ref_mem[ea[7:2]] = ed;
    if (r1 && !g1) denied1 = (denied1 < MAX_WAIT) ? denied1 + 1 : MAX_WAIT;
    else           denied1 = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
    end
    tb_mem[3]  = 32'd3;
    ref_mem[3] = 32'd3;
    reset_model();

    // Reset state, with a write request pending that must not reach memory.
    reset_n = 1'b0;
    drive_idle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd16; wdata0 = 32'hDEAD;
    #3;
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_rvalid0",   rvalid0,   1'b0);
    check("rst_rvalid1",   rvalid1,   1'b0);
    check("rst_rdata0",    rdata0,    32'd0);
    check("rst_rdata1",    rdata1,    32'd0);
    check("rst_err1",      err1,      1'b0);
    #9;
    drive_idle();
    #10;
    reset_n = 1'b1;

    // Port-0 read of word 12, then a write/read of 20.
    step(1, 0, 32'd12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'd20, 32'd0, 0, 0, 0, 0);
    step(1, 0, 32'd20, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Starvation: port 0 held, port 1 forced through after MAX_WAIT denials.
    for (int i = 0; i < 7; i++) step(1, 0, 32'd4, 0, 1, 0, 32'd12, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Port-1 misaligned write is dropped and flagged; word 20 keeps its value.
    step(0, 0, 0, 0, 1, 1, 32'd22, 32'd7);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'd20, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset one cycle after a granted read.
    step(1, 0, 32'd12, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_rst_rvalid0", rvalid0, exp_rv0);
    check("pre_rst_rdata0",  rdata0,  exp_rd0);
    drive_idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_rvalid0", rvalid0, 1'b0);
    check("async_rst_rdata0",  rdata0,  32'd0);
    check("async_rst_err1",    err1,    1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    reset_model();
    step(0, 0, 0, 0, 1, 0, 32'd12, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Alternating single-port reads every cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 0, (i % 4 == 0) ? 32'd12 : 32'd20, 0, 0, 0, 0, 0);
      else            step(0, 0, 0, 0, 1, 0, (i % 4 == 1) ? 32'd20 : 32'd12, 0);
    end

    // Random traffic, biased so port 1 is often starved.
    for (int i = 0; i < 400; i++) begin
      logic        r0, w0, r1, w1;
      logic [31:0] a0, a1, d0, d1;
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      w0 = $urandom_range(0, 1);
      w1 = $urandom_range(0, 1);
      a0 = ($urandom_range(0, 63) << 2) | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      a1 = ($urandom_range(0, 63) << 2) | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      d0 = $urandom;
      d1 = $urandom;
      step(r0, w0, a0, d0, r1, w1, a1, d1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the loader/debug port.
- Decides each cycle which requester drives the memory's write, address and write_data inputs.
- Returns the memory's combinational read_data to the winning requester as registered data one cycle later.
- Port 0 has priority; a starvation counter forces a port-1 grant after MAX_WAIT consecutive denied cycles.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- MAX_WAIT, 4, consecutive denied cycles for port 1 before a port-1 grant is forced (must be at least 1).
- CW, 3, width of the wait counter (must satisfy 2^CW > MAX_WAIT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  AW  port 0 byte address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 access accepted this cycle (combinational).
- stall0  out  1  req0 & ~gnt0; freezes the pipeline.
- rvalid0  out  1  port 0 read data valid (1-cycle pulse).
- rdata0  out  DW  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same meanings for port 1.
- err1  out  1  port 1 misaligned access, pulses alongside rvalid1 timing.
- mem_write  out  1  to data memory write input.
- mem_address  out  AW  to data memory address input.
- mem_write_data  out  DW  to data memory write_data input.
- mem_read_data  in  DW  from data memory read_data (combinational read).

Behaviour:
- Memory model: the write commits at the rising clk edge while mem_write=1; the read is combinational from mem_address.
- FSM states: NORMAL, FORCE1.
- NORMAL grants:
  - req0 → gnt0=1.
  - else req1 → gnt1=1.
  - else no grant.
- FORCE1 grants: req1 → gnt1=1 (gnt0=0); if req1 has dropped, behave as NORMAL for that cycle.
- Exactly one of gnt0/gnt1 is high in a cycle, or neither. No grant is ever given without the matching req.
- Wait counter wcnt (CW bits):
  - Reset 0.
  - Increments when req1 & ~gnt1, saturating at MAX_WAIT.
  - Clears on gnt1 or ~req1.
- FSM transitions:
  - NORMAL → FORCE1 when the next wcnt equals MAX_WAIT.
  - FORCE1 → NORMAL on gnt1 or ~req1.
- Memory drive:
  - mem_address/mem_write_data come from the granted port.
  - With no grant: address 0, data 0.
  - mem_write = granted we & aligned & reset_n.
- Alignment rule:
  - An access with addr[1:0] != 0 is still granted, but the write is suppressed.
  - For port 1, err1 pulses the cycle after the grant.
  - For port 0, the misaligned write is silently dropped; a misaligned read returns mem_read_data with no error (the pipeline handles exceptions upstream).
- Read return latency = 1:
  - On a granted read (we=0), the flop captures mem_read_data at the edge.
  - rvalidN=1 in the following cycle only; rdataN holds its value until the next granted read on that port.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle, including an alternating 0/1 pattern.
- Simultaneous req0 & req1 in NORMAL: port 0 wins; stall is not asserted on port 1 (port 1 simply waits).
- Reset values: FSM=NORMAL, wcnt=0, rvalid0/1=0, rdata0/1=0, err1=0. mem_write=0 while reset_n=0.
- Reset asserted mid-operation: any pending rvalid/err is dropped immediately (asynchronous); after release, the first grant follows the NORMAL rules.

Decomposition:
- Shared package dmem_pkg:
  - State encoding constants ST_NORMAL=1'b0, ST_FORCE1=1'b1.
  - Default widths AW/DW.
- One natural sub-module: dmem_rsp_reg (per-port read-return flop: rvalid, rdata, err; async reset), instantiated twice.

Test Plan:
- Memory preloaded word[12]=3. req0=1, we0=0, addr0=12 for one cycle → gnt0=1 that cycle; next cycle rvalid0=1, rdata0=3; rvalid1=0.
- Port-0 write: req0, we0=1, addr0=20, wdata0=0, then read 20 → mem_write=1 for one cycle only; the subsequent read gives rdata0=0, rvalid0 one cycle after the read grant.
- req0 held high continuously with req1=1, addr1=12, MAX_WAIT=4 → port 0 granted 4 cycles, then gnt1=1 on cycle 5 (stall0=1 that cycle); next cycle rvalid1=1, rdata1=3; then NORMAL resumes.
- Port-1 misaligned write: addr1=22, we1=1, wdata1=7 → gnt1=1, mem_write=0, err1=1 next cycle. A read of 20 then returns its prior value.
- reset_n driven low the cycle after a granted read → rvalid0 falls to 0 without waiting for clk; rdata0=0, FSM=NORMAL, wcnt=0. After release, req1 alone is granted immediately.
- Alternating req0/req1 reads of 12 and 20 every cycle → one grant per cycle, no double grant; each rvalid pulse is attributed to the correct port with the correct data.
